// File: rtl/cam_color_stats.sv
// Passive colour statistics for one captured frame: classifies each RGB332 pixel
// written to the frame buffer and reports per-class counts plus the dominant colour.
module cam_color_stats #(
    parameter int AW      = 15,
    parameter int NPIX    = 19200,
    parameter int CW      = 15,
    parameter int MIN_CNT = 64
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          start,
    input  logic          px_wr,
    input  logic [AW-1:0] mem_px_addr,
    input  logic [7:0]    mem_px_data,
    input  logic          frame_error,
    output logic          busy,
    output logic          valid,
    output logic          error,
    output logic [CW-1:0] cnt_red,
    output logic [CW-1:0] cnt_green,
    output logic [CW-1:0] cnt_blue,
    output logic [CW-1:0] cnt_other,
    output logic [1:0]    dominant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACC,
        S_DRAIN,
        S_RESULT,
        S_ABORT
    } state_t;

    state_t        state_q;
    logic          start_q, fe_q;
    logic [AW-1:0] last_addr_q, exp_q;
    logic          last_vld_q;
    logic          drain_q;
    logic          busy_q, valid_q, error_q;
    logic [1:0]    dom_q;

    logic          s1_vld_q;
    logic [3:0]    s1_cls_q;
    logic [CW-1:0] red_q, green_q, blue_q, other_q;

    // ---------------------------------------------------------------- classify
    logic [2:0] r_d, g_d;
    logic [1:0] b_d;
    logic       is_red_d, is_green_d, is_blue_d;
    logic [3:0] cls_d;

    always_comb begin
        r_d        = mem_px_data[7:5];
        g_d        = mem_px_data[4:2];
        b_d        = mem_px_data[1:0];
        is_red_d   = (r_d >= 3'd4) && (g_d <= 3'd2) && (b_d <= 2'd1);
        is_green_d = (g_d >= 3'd4) && (r_d <= 3'd2) && (b_d <= 2'd1);
        is_blue_d  = (b_d >= 2'd2) && (r_d <= 3'd2) && (g_d <= 3'd2);
        cls_d      = {~(is_red_d | is_green_d | is_blue_d), is_blue_d, is_green_d, is_red_d};
    end

    // ---------------------------------------------------------------- control decode
    logic start_rise_d, fe_rise_d, px_new_d;
    logic arm_hit_d, acc_ok_d, count_d, clr_d;

    always_comb begin
        start_rise_d = start & ~start_q;
        fe_rise_d    = frame_error & ~fe_q;
        // A held strobe repeats the same address; only the first cycle counts.
        px_new_d     = px_wr && (!last_vld_q || (mem_px_addr != last_addr_q));
        arm_hit_d    = (state_q == S_ARM) && px_new_d && (mem_px_addr == '0);
        acc_ok_d     = (state_q == S_ACC) && px_new_d && !fe_rise_d && (mem_px_addr == exp_q);
        count_d      = arm_hit_d || acc_ok_d;
        clr_d        = (state_q == S_IDLE) && start_rise_d;
    end

    // ---------------------------------------------------------------- result select
    logic [1:0]    win_cls_d, dom_d;
    logic [CW-1:0] win_cnt_d;

    always_comb begin
        win_cls_d = 2'd1;
        win_cnt_d = red_q;
        if ((red_q >= green_q) && (red_q >= blue_q)) begin
            win_cls_d = 2'd1;
            win_cnt_d = red_q;
        end else if (green_q >= blue_q) begin
            win_cls_d = 2'd2;
            win_cnt_d = green_q;
        end else begin
            win_cls_d = 2'd3;
            win_cnt_d = blue_q;
        end
        dom_d = (win_cnt_d >= CW'(MIN_CNT)) ? win_cls_d : 2'd0;
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---------------------------------------------------------------- pipeline + counters
    // NOTE: reset is synchronous (sampled on pclk), and all state uses non-blocking
    // assignments so every register sees the pre-edge values of its neighbours.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s1_cls_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            other_q  <= '0;
        end else begin
            s1_vld_q <= count_d;
            s1_cls_q <= cls_d;
            if (clr_d) begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
                other_q <= '0;
            end else if (s1_vld_q) begin
                if (s1_cls_q[0]) red_q   <= sat_inc(red_q);
                if (s1_cls_q[1]) green_q <= sat_inc(green_q);
                if (s1_cls_q[2]) blue_q  <= sat_inc(blue_q);
                if (s1_cls_q[3]) other_q <= sat_inc(other_q);
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            fe_q        <= 1'b0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            exp_q       <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            dom_q       <= 2'd0;
        end else begin
            start_q <= start;
            fe_q    <= frame_error;
            if (((state_q == S_ARM) || (state_q == S_ACC)) && px_new_d) begin
                last_addr_q <= mem_px_addr;
                last_vld_q  <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_rise_d) begin
                        state_q    <= S_ARM;
                        busy_q     <= 1'b1;
                        valid_q    <= 1'b0;
                        error_q    <= 1'b0;
                        dom_q      <= 2'd0;
                        last_vld_q <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (arm_hit_d) begin
                        state_q <= S_ACC;
                        exp_q   <= AW'(1);
                    end
                end
                S_ACC: begin
                    // An early address 0 is caught here too: exp_q is never 0 in ACC.
                    if (fe_rise_d || (px_new_d && (mem_px_addr != exp_q))) begin
                        state_q <= S_ABORT;
                    end else if (px_new_d) begin
                        if (exp_q == AW'(NPIX - 1)) begin
                            state_q <= S_DRAIN;
                            drain_q <= 1'b0;
                        end else begin
                            exp_q <= exp_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= S_RESULT;
                end
                S_RESULT: begin
                    dom_q   <= dom_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    error_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    dom_q   <= 2'd0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign dominant  = dom_q;
    assign cnt_red   = red_q;
    assign cnt_green = green_q;
    assign cnt_blue  = blue_q;
    assign cnt_other = other_q;

endmodule

// File: tb/tb_cam_color_stats.sv
// Directed bench for cam_color_stats on a reduced 1200-pixel frame so that every
// scenario completes in a few thousand cycles.
module tb_cam_color_stats;

    localparam int AW      = 15;
    localparam int NPIX    = 1200;
    localparam int CW      = 15;
    localparam int MIN_CNT = 64;

    logic          pclk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          px_wr = 1'b0;
    logic [AW-1:0] mem_px_addr = '0;
    logic [7:0]    mem_px_data = '0;
    logic          frame_error = 1'b0;
    logic          busy, valid, error;
    logic [CW-1:0] cnt_red, cnt_green, cnt_blue, cnt_other;
    logic [1:0]    dominant;

    cam_color_stats #(.AW(AW), .NPIX(NPIX), .CW(CW), .MIN_CNT(MIN_CNT)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .start       (start),
        .px_wr       (px_wr),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .frame_error (frame_error),
        .busy        (busy),
        .valid       (valid),
        .error       (error),
        .cnt_red     (cnt_red),
        .cnt_green   (cnt_green),
        .cnt_blue    (cnt_blue),
        .cnt_other   (cnt_other),
        .dominant    (dominant)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Mode 0: 625 red, 313 green, 262 blue. Modes 2/3: 63/64 green then white.
    function automatic logic [7:0] pix_of(input int mode, input int a);
        case (mode)
            0:       return (a < 625) ? 8'hE0 : (a < 938) ? 8'h1C : 8'h03;
            2:       return (a < 63) ? 8'h1C : 8'hFF;
            3:       return (a < 64) ? 8'h1C : 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic stream(input int mode, input int first, input int last, input int hold);
        for (int a = first; a <= last; a++) begin
            px_wr       = 1'b1;
            mem_px_addr = AW'(a);
            mem_px_data = pix_of(mode, a);
            repeat (hold) tick();
        end
        px_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic check_counts(input string tag, input int r, input int g, input int b, input int o);
        check({tag, "_red"}, cnt_red, r);
        check({tag, "_green"}, cnt_green, g);
        check({tag, "_blue"}, cnt_blue, b);
        check({tag, "_other"}, cnt_other, o);
    endtask

    initial begin
        int total;

        // Reset
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_error", error, 0);
        check("rst_dom", dominant, 0);
        check_counts("rst", 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // Single-cycle strobes, full frame
        pulse_start();
        check("t1_busy_armed", busy, 1);
        stream(0, 0, NPIX - 1, 1);
        repeat (2) tick();
        check("t1_busy_mid", busy, 1);
        tick();
        check("t1_busy_done", busy, 0);
        check("t1_valid", valid, 1);
        check("t1_error", error, 0);
        check_counts("t1", 625, 313, 262, 0);
        check("t1_dom", dominant, 1);

        // Start mid-frame: addresses 500.. ignored until address 0
        pulse_start();
        check("t2_valid_cleared", valid, 0);
        stream(0, 500, NPIX - 1, 1);
        check("t2_still_busy", busy, 1);
        stream(0, 0, NPIX - 1, 1);
        repeat (4) tick();
        total = int'(cnt_red) + int'(cnt_green) + int'(cnt_blue) + int'(cnt_other);
        check("t2_total", total, NPIX);
        check_counts("t2", 625, 313, 262, 0);
        check("t2_valid", valid, 1);

        // Every strobe held two cycles: no double counting
        pulse_start();
        stream(0, 0, NPIX - 1, 2);
        repeat (4) tick();
        check_counts("t3", 625, 313, 262, 0);
        check("t3_dom", dominant, 1);

        // All white, then 63 and 64 green pixels around the MIN_CNT threshold
        pulse_start();
        stream(1, 0, NPIX - 1, 1);
        repeat (4) tick();
        check("t4_other", cnt_other, NPIX);
        check("t4_dom", dominant, 0);
        check("t4_valid", valid, 1);

        pulse_start();
        stream(2, 0, NPIX - 1, 1);
        repeat (4) tick();
        check("t5_green", cnt_green, 63);
        check("t5_dom", dominant, 0);

        pulse_start();
        stream(3, 0, NPIX - 1, 1);
        repeat (4) tick();
        check("t6_green", cnt_green, 64);
        check("t6_other", cnt_other, NPIX - 64);
        check("t6_dom", dominant, 2);

        // Address jump 700 -> 702
        pulse_start();
        stream(0, 0, 700, 1);
        stream(0, 702, 702, 1);
        repeat (3) tick();
        check("t7_error", error, 1);
        check("t7_valid", valid, 0);
        check("t7_busy", busy, 0);
        check("t7_dom", dominant, 0);
        total = int'(cnt_red) + int'(cnt_green) + int'(cnt_blue) + int'(cnt_other);
        check("t7_total", total, 701);

        // frame_error rising together with pixel 300: abort, pixel 300 not counted
        pulse_start();
        check("t8_error_cleared", error, 0);
        stream(0, 0, 299, 1);
        frame_error = 1'b1;
        stream(0, 300, 300, 1);
        frame_error = 1'b0;
        repeat (3) tick();
        check("t8_error", error, 1);
        check("t8_busy", busy, 0);
        total = int'(cnt_red) + int'(cnt_green) + int'(cnt_blue) + int'(cnt_other);
        check("t8_total", total, 300);

        // Reset pulse mid-frame, then a clean measurement
        pulse_start();
        stream(0, 0, 899, 1);
        px_wr       = 1'b1;
        mem_px_addr = AW'(900);
        mem_px_data = pix_of(0, 900);
        rst         = 1'b0;
        tick();
        rst   = 1'b1;
        px_wr = 1'b0;
        check("t9_busy", busy, 0);
        check("t9_valid", valid, 0);
        check("t9_error", error, 0);
        check("t9_dom", dominant, 0);
        check_counts("t9", 0, 0, 0, 0);
        tick();
        pulse_start();
        stream(0, 0, NPIX - 1, 1);
        repeat (4) tick();
        check("t10_valid", valid, 1);
        check("t10_error", error, 0);
        check_counts("t10", 625, 313, 262, 0);
        check("t10_dom", dominant, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
